// File: rtl/inst_memory.sv
// Read-only, byte-addressable instruction ROM for the fetch stage.
// Registers a little-endian 32-bit word fetched at PC and the sequential PC + PC_STEP.
module inst_memory #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_BITS = 8,
  parameter int PC_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] PC,
  output logic [31:0] instruction,
  output logic [63:0] New_PC
);

  // ROM contents are a fixed ramp (byte[i] = i mod 256); there is no write path.
  logic [7:0] rom [MEM_BYTES];

  for (genvar i = 0; i < MEM_BYTES; i++) begin : g_rom
    assign rom[i] = 8'(i % 256);
  end

  logic [ADDR_BITS-1:0] byte_addr [4];
  logic [31:0]          fetch_word;
  logic [63:0]          next_pc;

  // Byte addresses wrap within ADDR_BITS, so fetches straddling the top land at 0.
  always_comb begin
    fetch_word = '0;
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = PC[ADDR_BITS-1:0] + ADDR_BITS'(k);
      fetch_word[8*k +: 8] = rom[byte_addr[k]];
    end
  end

  assign next_pc = PC + 64'(PC_STEP);

  // Power-up value is zero; reset has priority over the fetch.
  logic [31:0] instruction_q = '0;
  logic [63:0] new_pc_q      = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction_q <= '0;
      new_pc_q      <= '0;
    end else begin
      instruction_q <= fetch_word;
      new_pc_q      <= next_pc;
    end
  end

  assign instruction = instruction_q;
  assign New_PC      = new_pc_q;

endmodule

// File: tb/tb_inst_memory.sv
// Self-checking bench for inst_memory: directed vector table, feedback loop,
// and randomized fetches scored against an arithmetic ROM model.
module tb_inst_memory;

  localparam int MEM_BYTES = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc  = '0;
  logic [31:0] instruction;
  logic [63:0] new_pc;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  logic [95:0] exp_q[$];

  inst_memory #(.MEM_BYTES(MEM_BYTES), .ADDR_BITS(8), .PC_STEP(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .PC          (pc),
    .instruction (instruction),
    .New_PC      (new_pc)
  );

  // clock block
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [63:0] pc;
    logic [31:0] exp_instr;
    logic [63:0] exp_new_pc;
  } vec_t;

  // Reference: each byte is its own address mod MEM_BYTES, then mod 256.
  function automatic logic [31:0] model_instr(input logic [63:0] addr);
    longint unsigned base, word;
    base = addr % MEM_BYTES;
    word = 0;
    for (int k = 0; k < 4; k++)
      word = word + ((((base + k) % MEM_BYTES) % 256) << (8 * k));
    return word[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver: apply inputs away from the edge, then sample #1 after the edge
  task automatic step(input logic r, input logic [63:0] p);
    @(negedge clk);
    rst = r;
    pc  = p;
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic r, input logic [63:0] p);
    if (r) exp_q.push_back(96'h0);
    else   exp_q.push_back({model_instr(p), p + 64'd4});
  endtask

  task automatic score(input string name);
    logic [95:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_instr"}, {32'h0, instruction}, {32'h0, e[95:64]});
    check({name, "_new_pc"}, new_pc, e[63:0]);
  endtask

  vec_t vecs[10];

  initial begin
    logic [63:0] fb_pc;
    logic [63:0] exp_pc;
    logic        r;
    logic [63:0] p;

    vecs[0] = '{1'b0, 64'hA,                   32'h0D0C0B0A, 64'hE};
    vecs[1] = '{1'b0, 64'hFE,                  32'h0100FFFE, 64'h102};
    vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0100FFFE, 64'h2};
    vecs[3] = '{1'b0, 64'h1_0000_0004,         32'h07060504, 64'h1_0000_0008};
    vecs[4] = '{1'b0, 64'h0,                   32'h03020100, 64'h4};
    vecs[5] = '{1'b1, 64'h55,                  32'h0,        64'h0};
    vecs[6] = '{1'b1, 64'h55,                  32'h0,        64'h0};
    vecs[7] = '{1'b0, 64'h10,                  32'h13121110, 64'h14};
    vecs[8] = '{1'b0, 64'h1FF,                 32'h020100FF, 64'h203};
    vecs[9] = '{1'b1, 64'h20,                  32'h0,        64'h0};

    // power-up value before any edge
    #1;
    check("powerup_instr", {32'h0, instruction}, 64'h0);
    check("powerup_new_pc", new_pc, 64'h0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].pc);
      check($sformatf("vec%0d_instr", i), {32'h0, instruction}, {32'h0, vecs[i].exp_instr});
      check($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].exp_new_pc);
    end

    // feedback loop: PC driven from New_PC, expected PC tracked independently
    fb_pc  = 64'hA;
    exp_pc = 64'hA;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, fb_pc);
      check($sformatf("loop%0d_instr", i), {32'h0, instruction}, {32'h0, model_instr(exp_pc)});
      check($sformatf("loop%0d_new_pc", i), new_pc, exp_pc + 64'd4);
      exp_pc = exp_pc + 64'd4;
      fb_pc  = new_pc;
    end
    check("loop_last_instr", {32'h0, instruction}, {32'h0, 32'h2D2C2B2A});
    check("loop_last_new_pc", new_pc, 64'h2E);

    // randomized fetches with occasional reset, scored through the expected queue
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       p = {$urandom, $urandom};
        1:       p = 64'hFFFF_FFFF_FFFF_FFFC + 64'($urandom_range(0, 3));
        2:       p = {$urandom, 24'h0, 8'($urandom_range(252, 255))};
        default: p = 64'($urandom_range(0, 511));
      endcase
      push_expected(r, p);
      step(r, p);
      score($sformatf("rand%0d", i));
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // run-time bound so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
